// File: rtl/apac_ctrl_p.sv
// Parking access controller: entry-gate FSM with PIN check, occupancy count and full-lot lockout.
// Optional OPEN/PIN state timeouts are compiled in when APAC_TIMEOUT_EN is defined.
module apac_ctrl_p #(
  parameter int              PW_W         = 8,
  parameter logic [PW_W-1:0] PASSWORD     = 8'b0101_0111,
  parameter int              MAX_ATTEMPTS = 3,
  parameter int              CAPACITY     = 16,
  parameter int              TIMEOUT      = 32,
  localparam int             AW           = $clog2(MAX_ATTEMPTS + 1),
  localparam int             OW           = $clog2(CAPACITY + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sensor_1,
  input  logic            sensor_2,
  input  logic [PW_W-1:0] psswrd_atmpt,
  input  logic            try_psswrd,
  input  logic            car_exit,
  output logic            alarm_1,
  output logic            alarm_2,
  output logic            open_gate,
  output logic            close_gate,
  output logic [2:0]      state,
  output logic [AW-1:0]   attempts,
  output logic [OW-1:0]   occupancy,
  output logic            full
);

  // state     | meaning
  // IDLE      | gate closed, waiting for a car at the entry
  // PIN       | car waiting, PIN session in progress
  // OPEN      | gate open, waiting for the car to pass
  // BLOCK     | both sensors hit, tailgate alarm until a correct PIN
  // PIN_ALARM | too many wrong PINs, held until reset
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PIN       = 3'd1;
  localparam logic [2:0] S_OPEN      = 3'd2;
  localparam logic [2:0] S_BLOCK     = 3'd3;
  localparam logic [2:0] S_PIN_ALARM = 3'd4;

  localparam logic [AW-1:0] ATT_MAX = AW'(MAX_ATTEMPTS);
  localparam logic [OW-1:0] OCC_MAX = OW'(CAPACITY);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] attempts_q, attempts_d, att_inc;
  logic [OW-1:0] occupancy_q, occupancy_d;
  logic          full_q, full_d;
  logic          try_q, exit_q;
  logic          alarm_1_q, alarm_1_d;
  logic          alarm_2_q, alarm_2_d;
  logic          open_gate_q, open_gate_d;
  logic          close_gate_q, close_gate_d;

  logic try_evt, exit_evt, entry_evt, pin_match, blk;

  assign try_evt   = try_psswrd & ~try_q;
  assign exit_evt  = car_exit & ~exit_q;
  assign pin_match = (psswrd_atmpt == PASSWORD);
  assign blk       = sensor_1 & sensor_2;
  assign att_inc   = attempts_q + AW'(1);

`ifdef APAC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          tmr_zero;

  assign tmr_zero = (tmr_q == '0);

  // Down-counter restarts on every state change and on each try in PIN.
  always_comb begin
    tmr_d = tmr_q;
    if ((state_d != state_q) || ((state_q == S_PIN) && try_evt)) begin
      tmr_d = TMR_LOAD;
    end else if (!tmr_zero) begin
      tmr_d = tmr_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tmr_q <= TMR_LOAD;
    else     tmr_q <= tmr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      attempts_q   <= '0;
      occupancy_q  <= '0;
      full_q       <= 1'b0;
      try_q        <= 1'b0;
      exit_q       <= 1'b0;
      alarm_1_q    <= 1'b0;
      alarm_2_q    <= 1'b0;
      open_gate_q  <= 1'b0;
      close_gate_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      attempts_q   <= attempts_d;
      occupancy_q  <= occupancy_d;
      full_q       <= full_d;
      try_q        <= try_psswrd;
      exit_q       <= car_exit;
      alarm_1_q    <= alarm_1_d;
      alarm_2_q    <= alarm_2_d;
      open_gate_q  <= open_gate_d;
      close_gate_q <= close_gate_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    attempts_d = attempts_q;
    entry_evt  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (blk) begin
          state_d = S_BLOCK;
        end else if (sensor_1 && !full_q) begin
          state_d    = S_PIN;
          attempts_d = '0;
        end
      end
      S_PIN: begin
        if (blk) begin
          state_d = S_BLOCK;
        end else if (try_evt) begin
          if (pin_match) begin
            state_d    = S_OPEN;
            attempts_d = '0;
          end else begin
            attempts_d = att_inc;
            if (att_inc == ATT_MAX) state_d = S_PIN_ALARM;
          end
        end
`ifdef APAC_TIMEOUT_EN
        else if (tmr_zero) begin
          state_d    = S_IDLE;
          attempts_d = '0;
        end
`endif
      end
      S_OPEN: begin
        if (blk) begin
          state_d = S_BLOCK;
        end else if (sensor_2 && !sensor_1) begin
          state_d   = S_IDLE;
          entry_evt = 1'b1;
        end
`ifdef APAC_TIMEOUT_EN
        else if (tmr_zero) begin
          state_d = S_IDLE;
        end
`endif
      end
      S_BLOCK: begin
        if (try_evt && pin_match) begin
          state_d    = S_IDLE;
          attempts_d = '0;
        end
      end
      S_PIN_ALARM: state_d = S_PIN_ALARM;
      default:     state_d = S_IDLE;
    endcase
  end

  // Entry and exit on the same edge cancel; both ends saturate.
  always_comb begin
    occupancy_d = occupancy_q;
    if (entry_evt && !exit_evt) begin
      if (occupancy_q != OCC_MAX) occupancy_d = occupancy_q + OW'(1);
    end else if (exit_evt && !entry_evt) begin
      if (occupancy_q != '0) occupancy_d = occupancy_q - OW'(1);
    end
    full_d = (occupancy_d == OCC_MAX);
  end

  always_comb begin
    open_gate_d  = (state_d == S_OPEN);
    close_gate_d = (state_d != S_OPEN);
    alarm_1_d    = (state_d == S_PIN_ALARM);
    alarm_2_d    = (state_d == S_BLOCK);
  end

  assign state      = state_q;
  assign attempts   = attempts_q;
  assign occupancy  = occupancy_q;
  assign full       = full_q;
  assign alarm_1    = alarm_1_q;
  assign alarm_2    = alarm_2_q;
  assign open_gate  = open_gate_q;
  assign close_gate = close_gate_q;

endmodule

// File: tb/tb_apac_ctrl_p.sv
// Directed bench for apac_ctrl_p with CAPACITY=2 and TIMEOUT=8.
module tb_apac_ctrl_p;
  localparam int AW = 2;
  localparam int OW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sensor_1 = 1'b0, sensor_2 = 1'b0;
  logic [7:0]    psswrd_atmpt = 8'h00;
  logic          try_psswrd = 1'b0, car_exit = 1'b0;
  logic          alarm_1, alarm_2, open_gate, close_gate, full;
  logic [2:0]    state;
  logic [AW-1:0] attempts;
  logic [OW-1:0] occupancy;

  int n_chk = 0;
  int n_err = 0;

  apac_ctrl_p #(
    .PW_W(8), .PASSWORD(8'h57), .MAX_ATTEMPTS(3), .CAPACITY(2), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .sensor_1(sensor_1), .sensor_2(sensor_2),
    .psswrd_atmpt(psswrd_atmpt), .try_psswrd(try_psswrd), .car_exit(car_exit),
    .alarm_1(alarm_1), .alarm_2(alarm_2), .open_gate(open_gate),
    .close_gate(close_gate), .state(state), .attempts(attempts),
    .occupancy(occupancy), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_try(input logic [7:0] pin);
    psswrd_atmpt = pin;
    try_psswrd   = 1'b1;
    tick();
    try_psswrd   = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(5);
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_close", close_gate, 1);
    chk("rst_open", open_gate, 0);
    chk("rst_alarms", {alarm_1, alarm_2}, 0);
    chk("rst_att", attempts, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_full", full, 0);

    // normal entry
    sensor_1 = 1'b1; tick();
    chk("ent_pin", state, 1);
    chk("ent_pin_open", open_gate, 0);
    psswrd_atmpt = 8'h57; try_psswrd = 1'b1; tick();
    chk("ent_open", state, 2);
    chk("ent_open_gate", {open_gate, close_gate}, 2'b10);
    try_psswrd = 1'b0; sensor_1 = 1'b0; tick();
    sensor_2 = 1'b1; tick();
    chk("ent_idle", state, 0);
    chk("ent_closed", {open_gate, close_gate}, 2'b01);
    chk("ent_occ", occupancy, 1);
    sensor_2 = 1'b0; tick();

    // two wrong, then right; lot becomes full
    sensor_1 = 1'b1; tick();
    do_try(8'h5F);
    chk("wr1_att", attempts, 1);
    do_try(8'h5F);
    chk("wr2_att", attempts, 2);
    chk("wr2_alarm1", alarm_1, 0);
    do_try(8'h57);
    chk("wr_ok_att", attempts, 0);
    chk("wr_ok_state", state, 2);
    chk("wr_ok_alarm1", alarm_1, 0);
    sensor_1 = 1'b0; tick();
    sensor_2 = 1'b1; tick();
    sensor_2 = 1'b0;
    chk("full_occ", occupancy, 2);
    chk("full_flag", full, 1);
    sensor_1 = 1'b1; tick(3);
    chk("full_lockout", state, 0);
    sensor_1 = 1'b0;

    // exit held high three cycles counts once
    car_exit = 1'b1; tick(3);
    car_exit = 1'b0; tick();
    chk("exit_occ", occupancy, 1);
    chk("exit_full", full, 0);

    // entry and exit on the same edge
    sensor_1 = 1'b1; tick();
    do_try(8'h57);
    sensor_1 = 1'b0; tick();
    sensor_2 = 1'b1; car_exit = 1'b1; tick();
    chk("simul_state", state, 0);
    chk("simul_occ", occupancy, 1);
    sensor_2 = 1'b0; car_exit = 1'b0; tick();

    // exits saturate at zero
    for (int i = 0; i < 4; i++) begin
      car_exit = 1'b1; tick();
      car_exit = 1'b0; tick();
    end
    chk("exit_sat", occupancy, 0);

    // block in IDLE
    sensor_1 = 1'b1; sensor_2 = 1'b1; tick();
    chk("blk_state", state, 3);
    chk("blk_alarm2", alarm_2, 1);
    chk("blk_closed", close_gate, 1);
    do_try(8'h5F);
    chk("blk_wrong_state", state, 3);
    chk("blk_wrong_att", attempts, 0);
    sensor_1 = 1'b0; sensor_2 = 1'b0;
    do_try(8'h57);
    chk("blk_clear_state", state, 0);
    chk("blk_clear_alarm2", alarm_2, 0);

    // held try counts once
    sensor_1 = 1'b1; tick();
    psswrd_atmpt = 8'h5F; try_psswrd = 1'b1; tick(4);
    try_psswrd = 1'b0; tick();
    chk("hold_att", attempts, 1);
    chk("hold_state", state, 1);
    sensor_1 = 1'b0;
    do_try(8'h57);
    chk("hold_open", state, 2);
`ifdef APAC_TIMEOUT_EN
    tick(6);
    chk("to_before", state, 2);
    tick();
    chk("to_state", state, 0);
    chk("to_close", close_gate, 1);
    chk("to_occ", occupancy, 0);
`else
    tick(20);
    chk("wait_open", state, 2);
    sensor_2 = 1'b1; tick();
    sensor_2 = 1'b0;
    chk("wait_idle", state, 0);
    chk("wait_occ", occupancy, 1);
`endif
    tick();

    // pin alarm and reset recovery
    sensor_1 = 1'b1; tick();
    for (int i = 0; i < 3; i++) do_try(8'h5F);
    chk("alm_state", state, 4);
    chk("alm_alarm1", alarm_1, 1);
    chk("alm_att", attempts, 3);
    do_try(8'h57);
    chk("alm_hold", state, 4);
    sensor_2 = 1'b1; tick();
    chk("alm_sens", state, 4);
    sensor_1 = 1'b0; sensor_2 = 1'b0;
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("alm_rst_state", state, 0);
    chk("alm_rst_alarm1", alarm_1, 0);
    chk("alm_rst_close", close_gate, 1);
    chk("alm_rst_occ", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
